// File: rtl/reset_sequencer.sv
// reset_sequencer: staged reset release for a Picoblaze system, async assert / sync sequenced deassert
module reset_sequencer #(
    parameter int NUM_CHANNELS = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 100,
    parameter int GAP_CYCLES = 16,
    parameter int CNT_WIDTH = 16,
    parameter logic [NUM_CHANNELS-1:0] ACTIVE_LOW_MASK = '0
) (
    input  logic                    CLK_IN,
    input  logic                    RESET_IN,
    input  logic                    SOFT_RESET_IN,
    output logic [NUM_CHANNELS-1:0] RESET_OUT,
    output logic                    DONE_OUT,
    output logic [1:0]              STATE_OUT
);

    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST = CNT_WIDTH'(GAP_CYCLES - 1);

    if (NUM_CHANNELS < 1) begin : g_bad_channels
        $error("reset_sequencer: NUM_CHANNELS must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("reset_sequencer: SYNC_STAGES must be >= 2");
    end
    if (HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_delay
        $error("reset_sequencer: HOLD_CYCLES and GAP_CYCLES must be >= 1");
    end
    if (CNT_WIDTH < 31 && (HOLD_CYCLES >= (1 << CNT_WIDTH) || GAP_CYCLES >= (1 << CNT_WIDTH))) begin : g_bad_width
        $error("reset_sequencer: CNT_WIDTH too small for HOLD_CYCLES/GAP_CYCLES");
    end

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_CHANNELS-1:0] rst_out_q, rst_out_d;
    logic                    done_q, done_d;
    logic                    sync_rst, restart, hold_hit, gap_hit;

    assign sync_rst  = sync_q[SYNC_STAGES-1];
    assign restart   = sync_rst | SOFT_RESET_IN;
    assign hold_hit  = cnt_q == HOLD_LAST;
    assign gap_hit   = cnt_q == GAP_LAST;
    assign RESET_OUT = rst_out_q;
    assign DONE_OUT  = done_q;
    assign STATE_OUT = state_q;

    // Release synchronizer: shifts zeros in once the raw reset is gone
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};
    end

    // State and datapath registers; raw reset forces every channel asserted immediately
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            sync_q    <= '1;
            state_q   <= S_HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= ~ACTIVE_LOW_MASK;
            done_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            done_q    <= done_d;
        end
    end

    // Next state: synchronized or soft reset pins the FSM in HOLD
    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = S_HOLD;
        end else begin
            case (state_q)
                S_HOLD:    state_d = hold_hit ? ((NUM_CHANNELS == 1) ? S_DONE : S_RELEASE) : S_HOLD;
                S_RELEASE: state_d = (gap_hit && idx_q == LAST_IDX) ? S_DONE : S_RELEASE;
                S_DONE:    state_d = S_DONE;
                default:   state_d = S_HOLD;
            endcase
        end
    end

    // Outputs and counters: release one channel per expired interval, never re-assert except on restart
    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        done_d    = done_q;
        if (restart) begin
            cnt_d     = '0;
            idx_d     = '0;
            rst_out_d = ~ACTIVE_LOW_MASK;
            done_d    = 1'b0;
        end else if (state_q == S_HOLD) begin
            cnt_d = hold_hit ? '0 : cnt_q + 1'b1;
            if (hold_hit) begin
                rst_out_d[0] = ACTIVE_LOW_MASK[0];
                idx_d        = (NUM_CHANNELS == 1) ? '0 : IDX_W'(1);
                done_d       = NUM_CHANNELS == 1;
            end
        end else if (state_q == S_RELEASE) begin
            cnt_d = gap_hit ? '0 : cnt_q + 1'b1;
            if (gap_hit) begin
                for (int i = 0; i < NUM_CHANNELS; i++)
                    if (idx_q == IDX_W'(i)) rst_out_d[i] = ACTIVE_LOW_MASK[i];
                idx_d  = (idx_q == LAST_IDX) ? idx_q : idx_q + 1'b1;
                done_d = idx_q == LAST_IDX;
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: random reset/soft-reset traffic against a release-time model
module tb_reset_sequencer;

    localparam int N4 = 4;
    localparam int S = 2;
    localparam int HOLD4 = 100;
    localparam int GAP4 = 16;
    localparam logic [3:0] M4 = 4'b0010;

    logic       clk = 1'b0;
    logic       rst_in = 1'b1;
    logic       soft_in = 1'b0;
    logic [3:0] r4;
    logic       d4;
    logic [1:0] s4;
    logic       r1;
    logic       d1;
    logic [1:0] s1;

    int n_tests = 0;
    int n_fail = 0;
    int lowcnt = 0;
    int run = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_CHANNELS(N4), .SYNC_STAGES(S), .HOLD_CYCLES(HOLD4), .GAP_CYCLES(GAP4),
        .CNT_WIDTH(16), .ACTIVE_LOW_MASK(M4)
    ) dut4 (
        .CLK_IN(clk), .RESET_IN(rst_in), .SOFT_RESET_IN(soft_in),
        .RESET_OUT(r4), .DONE_OUT(d4), .STATE_OUT(s4)
    );

    reset_sequencer #(
        .NUM_CHANNELS(1), .SYNC_STAGES(S), .HOLD_CYCLES(1), .GAP_CYCLES(1), .CNT_WIDTH(4)
    ) dut1 (
        .CLK_IN(clk), .RESET_IN(rst_in), .SOFT_RESET_IN(soft_in),
        .RESET_OUT(r1), .DONE_OUT(d1), .STATE_OUT(s1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Number of channels whose release time has been reached after r counting edges
    function automatic int rel_cnt(int r, int hold, int gap, int n);
        int c = 0;
        for (int i = 0; i < n; i++)
            if (r >= hold + i * gap) c++;
        return c;
    endfunction

    function automatic logic [3:0] exp_out4(int n);
        logic [3:0] e;
        for (int i = 0; i < 4; i++) e[i] = (i < n) ? M4[i] : ~M4[i];
        return e;
    endfunction

    function automatic logic [1:0] exp_state(int n, int nch);
        return (n == nch) ? 2'd2 : (n > 0) ? 2'd1 : 2'd0;
    endfunction

    task automatic check_all(input string tag);
        int n4, n1;
        n4 = rel_cnt(run, HOLD4, GAP4, N4);
        n1 = rel_cnt(run, 1, 1, 1);
        check({tag, ".out4"}, 32'(r4), 32'(exp_out4(n4)));
        check({tag, ".done4"}, 32'(d4), 32'(n4 == N4));
        check({tag, ".state4"}, 32'(s4), 32'(exp_state(n4, N4)));
        check({tag, ".out1"}, 32'(r1), 32'(n1 == 1 ? 1'b0 : 1'b1));
        check({tag, ".done1"}, 32'(d1), 32'(n1 == 1));
        check({tag, ".state1"}, 32'(s1), 32'(exp_state(n1, 1)));
    endtask

    // Model: counting edges begin SYNC_STAGES edges after reset is last sampled low, soft low
    always @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            lowcnt = 0;
            run = 0;
        end else begin
            if (lowcnt < 1000) lowcnt = lowcnt + 1;
            if (lowcnt > S && !soft_in) run = run + 1;
            else run = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        check_all("cyc");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_in = 1'b0;
        repeat (160) @(negedge clk);
        @(posedge clk);
        #2 rst_in = 1'b1;
        #1 check_all("async_done");
        @(negedge clk);
        rst_in = 1'b0;
        repeat (30) begin
            @(negedge clk);
            case ($urandom_range(0, 3))
                0: begin
                    rst_in = 1'b1;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    rst_in = 1'b0;
                end
                1: begin
                    #1 rst_in = 1'b1;
                    #1 check_all("glitch");
                    #1 rst_in = 1'b0;
                end
                2: begin
                    soft_in = 1'b1;
                    repeat ($urandom_range(1, 4)) @(negedge clk);
                    soft_in = 1'b0;
                end
                default: begin
                    rst_in = 1'b1;
                    soft_in = 1'b1;
                    repeat (2) @(negedge clk);
                    rst_in = 1'b0;
                    repeat ($urandom_range(1, 5)) @(negedge clk);
                    soft_in = 1'b0;
                end
            endcase
            repeat ($urandom_range(5, 180)) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Synthesizable clock-domain reset controller for Picoblaze-based designs.
- Takes one raw board reset and produces NUM_CHANNELS reset outputs.
- Each output asserts asynchronously; outputs deassert synchronously, one after another, with programmable hold and gap delays.
- Sits at the top level between the board clock/reset pins and the processor core, its peripherals and its memories. Adds per-channel polarity and a synchronous soft-reset restart.

Parameters:
- NUM_CHANNELS, 4: number of reset outputs; must be >=1.
- SYNC_STAGES, 2: depth of the reset deassertion synchronizer; must be >=2.
- HOLD_CYCLES, 100: cycles from synchronized reset release until channel 0 deasserts; must be >=1.
- GAP_CYCLES, 16: cycles between channel i and channel i+1 deasserting; must be >=1.
- CNT_WIDTH, 16: counter width; must satisfy 2**CNT_WIDTH > max(HOLD_CYCLES, GAP_CYCLES).
- ACTIVE_LOW_MASK, {NUM_CHANNELS{1'b0}}: bit i=1 makes RESET_OUT[i] active-low.

Ports:
- CLK_IN  input  1  system clock.
- RESET_IN  input  1  raw reset; asynchronous, active-high.
- SOFT_RESET_IN  input  1  synchronous soft reset request, level-sensitive, active-high.
- RESET_OUT  output  NUM_CHANNELS  per-channel resets; polarity per ACTIVE_LOW_MASK.
- DONE_OUT  output  1  high once every channel is released.
- STATE_OUT  output  2  FSM state: 0=HOLD, 1=RELEASE, 2=DONE.

Behaviour:
- Clocking and reset: one clock (CLK_IN); reset RESET_IN is asynchronous, active-high. All outputs are registered.
- RESET_IN asserted, without waiting for a clock edge:
  - sync chain goes to all ones;
  - RESET_OUT = ~ACTIVE_LOW_MASK (every channel in its asserted level);
  - DONE_OUT=0, STATE_OUT=0 (HOLD), counter=0, channel index=0.
- Synchronizer: sync_rst is the last flop of an SYNC_STAGES-deep chain that shifts in 0.
  - Let E0 be the first rising edge that samples RESET_IN low.
  - sync_rst falls at edge E(SYNC_STAGES-1).
  - While sync_rst=1, the FSM is held in the RESET_IN-asserted state described above.
- HOLD: counter increments every cycle. When counter==HOLD_CYCLES-1:
  - RESET_OUT[0] deasserts (takes the value ACTIVE_LOW_MASK[0]);
  - counter clears;
  - if NUM_CHANNELS==1, go to DONE; otherwise go to RELEASE with index=1.
- RELEASE: counter increments. When counter==GAP_CYCLES-1:
  - RESET_OUT[index] deasserts and counter clears;
  - if index==NUM_CHANNELS-1, go to DONE; otherwise index increments.
- Release timing: channel i deasserts at edge E(SYNC_STAGES-1+HOLD_CYCLES+i*GAP_CYCLES).
- DONE: DONE_OUT is set on the same edge that deasserts the last channel. All outputs are then static until the next reset.
- Released channels stay released. No channel ever re-asserts, except through RESET_IN or SOFT_RESET_IN.
- SOFT_RESET_IN=1 sampled on an edge, in any state, when sync_rst=0:
  - RESET_OUT=~ACTIVE_LOW_MASK, DONE_OUT=0, counter=0, index=0, state=HOLD.
  - While it stays high, the FSM remains in HOLD with counter=0.
  - Counting restarts on the first edge that samples it low. Channel 0 then releases HOLD_CYCLES edges later, counting that edge as 1.
- Priority: RESET_IN/sync_rst > SOFT_RESET_IN > normal sequencing.
- Mid-sequence events: RESET_IN or SOFT_RESET_IN arriving mid-sequence re-asserts every channel at once, including channels already released, then restarts the full sequence.
- Glitches: a RESET_IN pulse shorter than one clock still asserts all outputs and forces a full SYNC_STAGES + HOLD_CYCLES delay.
- Counter: never wraps in legal configurations. Parameter checks are enforced by an elaboration-time error.
- STATE_OUT encoding value 3 is unused and never driven.

Test Plan:
- Defaults (4 ch, SYNC=2, HOLD=100, GAP=16), 10 ns clock, RESET_IN high 100..1100 ns:
  - RESET_OUT=4'hF and DONE_OUT=0 immediately on assertion;
  - channel 0 clears at E101, 1 at E117, 2 at E133, 3 at E149;
  - DONE_OUT=1 and STATE_OUT=2 at E149.
- Async assert: RESET_IN rises 2 ns after an edge while in DONE -> RESET_OUT=4'hF and DONE_OUT=0 within the same cycle, before the next edge.
- SOFT_RESET_IN held 3 cycles after channel 1 releases:
  - RESET_OUT returns to 4'hF on the first sampling edge and STATE_OUT=0;
  - channel 0 releases 100 edges after the edge that samples SOFT_RESET_IN low.
- ACTIVE_LOW_MASK=4'b0010:
  - reset value is 4'b1101;
  - after the full sequence RESET_OUT=4'b0010, with the same release edges as the defaults scenario.
- NUM_CHANNELS=1, HOLD_CYCLES=1, GAP_CYCLES=1, SYNC=2 -> RESET_OUT[0] and DONE_OUT both change at E2.
- SOFT_RESET_IN and RESET_IN asserted together; RESET_IN drops first -> the sequence does not start until SOFT_RESET_IN is sampled low, and timing is then measured from that edge.
